// File: rtl/mod_exp_engine_if.sv
// Request/response bundle between the prime generator and the modular exponentiation engine.
interface mod_exp_engine_if #(
    parameter int DATA_WIDTH = 512,
    parameter int E_WIDTH    = 3,
    parameter int SIZE_WIDTH = 10
);
    logic                          start;
    logic [DATA_WIDTH-1:0]         x;
    logic [DATA_WIDTH+E_WIDTH-1:0] y;
    logic [SIZE_WIDTH-1:0]         y_size;
    logic [DATA_WIDTH-1:0]         m;
    logic                          ready;
    logic [DATA_WIDTH-1:0]         out;

    modport master (output start, x, y, y_size, m, input ready, out);
    modport slave  (input start, x, y, y_size, m, output ready, out);
endinterface

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply x^y mod m, built on a bit-serial
// interleaved shift-add modular multiplier (one multiplier bit per cycle).
module mod_exp_engine #(
    parameter int DATA_WIDTH = 512,
    parameter int E_WIDTH    = 3,
    parameter int SIZE_WIDTH = 10
) (
    input logic             clk,
    input logic             rst,
    mod_exp_engine_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int YW = DATA_WIDTH + E_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {IDLE, REDUCE, SQUARE, MULT, DONE} state_t;
    state_t state_q, state_d;

    logic                  start_q;
    logic [W-1:0]          x_q, x_d, m_q, m_d, xr_q, xr_d, res_q, res_d, out_q, out_d;
    logic [YW-1:0]         y_q, y_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d, i_q, i_d, size_clamp;
    logic [CW-1:0]         bidx_q, bidx_d;
    logic [W+1:0]          acc_q, acc_d, step;
    logic                  ready_q, ready_d;
    logic                  accept, busy, last_bit, m_small, y_bit, b_bit;
    logic [W-1:0]          a_sel, b_sel;

    // One interleaved step: double, reduce, conditionally add a, reduce. acc stays < m.
    function automatic logic [W+1:0] mm_step(input logic [W+1:0] acc, input logic [W-1:0] a,
                                             input logic [W-1:0] m, input logic b);
        logic [W+1:0] t, mx;
        mx = {2'b00, m};
        t  = {acc[W:0], 1'b0};
        if (t >= mx) t = t - mx;
        if (b) t = t + {2'b00, a};
        if (t >= mx) t = t - mx;
        return t;
    endfunction

    assign size_clamp = (32'(bus.y_size) > 32'(YW)) ? SIZE_WIDTH'(YW) : bus.y_size;
    assign accept     = bus.start && !start_q && (state_q == IDLE || state_q == DONE);
    assign busy       = (state_q == REDUCE) || (state_q == SQUARE) || (state_q == MULT);
    assign last_bit   = (bidx_q == '0);
    assign m_small    = (m_q[W-1:1] == '0);
    assign y_bit      = |(y_q & (YW'(1) << i_q));
    assign b_bit      = |(b_sel & (W'(1) << bidx_q));
    assign step       = mm_step(acc_q, a_sel, m_q, b_bit);

    always_comb begin
        a_sel = res_q;
        b_sel = res_q;
        if (state_q == REDUCE) begin
            a_sel = W'(1);
            b_sel = x_q;
        end else if (state_q == MULT) begin
            b_sel = xr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (accept) state_d = REDUCE;
            REDUCE: begin
                if (m_small)       state_d = DONE;
                else if (last_bit) state_d = (size_q == '0) ? DONE : SQUARE;
            end
            SQUARE: begin
                if (last_bit) begin
                    if (y_bit)          state_d = MULT;
                    else if (i_q == '0) state_d = DONE;
                end
            end
            MULT:    if (last_bit) state_d = (i_q == '0) ? DONE : SQUARE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        m_d     = m_q;
        size_d  = size_q;
        i_d     = i_q;
        xr_d    = xr_q;
        res_d   = res_q;
        acc_d   = acc_q;
        bidx_d  = bidx_q;
        ready_d = (state_q == DONE);
        out_d   = (state_q == DONE) ? res_q : out_q;
        if (accept) begin
            x_d    = bus.x;
            y_d    = bus.y;
            m_d    = bus.m;
            size_d = size_clamp;
            i_d    = size_clamp - SIZE_WIDTH'(1);
            res_d  = W'(1);
            acc_d  = '0;
            bidx_d = CW'(W - 1);
        end else if (busy) begin
            acc_d  = step;
            bidx_d = bidx_q - CW'(1);
            if (state_q == REDUCE && m_small) begin
                res_d = '0;
            end else if (last_bit) begin
                acc_d  = '0;
                bidx_d = CW'(W - 1);
                case (state_q)
                    REDUCE: xr_d = step[W-1:0];
                    SQUARE: begin
                        res_d = step[W-1:0];
                        if (!y_bit && i_q != '0) i_d = i_q - SIZE_WIDTH'(1);
                    end
                    default: begin
                        res_d = step[W-1:0];
                        if (i_q != '0) i_d = i_q - SIZE_WIDTH'(1);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            start_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            size_q  <= '0;
            i_q     <= '0;
            xr_q    <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            bidx_q  <= '0;
            ready_q <= 1'b0;
            out_q   <= '0;
        end else begin
            start_q <= bus.start;
            x_q     <= x_d;
            y_q     <= y_d;
            m_q     <= m_d;
            size_q  <= size_d;
            i_q     <= i_d;
            xr_q    <= xr_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            bidx_q  <= bidx_d;
            ready_q <= ready_d;
            out_q   <= out_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.out   = out_q;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed and randomized bench for mod_exp_engine at DATA_WIDTH=16, against a pow-mod model.
module tb_mod_exp_engine;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mod_exp_engine_if #(.DATA_WIDTH(W), .E_WIDTH(3), .SIZE_WIDTH(10)) bus ();

    mod_exp_engine #(.DATA_WIDTH(W), .E_WIDTH(3), .SIZE_WIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Right-to-left exponentiation over plain integers.
    function automatic longint ref_powmod(longint x, longint y, int sz, longint m);
        longint base, r;
        if (m < 2) return 0;
        base = x % m;
        r    = 1;
        for (int b = 0; b < sz; b++) begin
            if (((y >> b) & 1) == 1) r = (r * base) % m;
            base = (base * base) % m;
        end
        return r;
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic run_op(input logic [15:0] x, input logic [18:0] y, input logic [9:0] ys,
                          input logic [15:0] m, input int pulse_at, input bit hold,
                          input bit from_done, input string tag);
        longint      expv;
        int          expl, sz, lat;
        logic [18:0] mask;
        sz   = (ys > 10'd19) ? 19 : int'(ys);
        mask = 19'((20'h1 << sz) - 20'h1);
        expv = ref_powmod(longint'(x), longint'(y), sz, longint'(m));
        expl = (m < 16'd2) ? 2 : W * (1 + sz + $countones(y & mask)) + 1;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.x      = x;
        bus.y      = y;
        bus.y_size = ys;
        bus.m      = m;
        @(posedge clk);
        #1;
        if (from_done) chk(32'(bus.ready), 32'd1, {tag, "_ready_at_start_edge"});
        lat = 0;
        for (int n = 1; n <= 2000 && lat == 0; n++) begin
            @(negedge clk);
            bus.start  = hold || (n == pulse_at);
            bus.x      = 16'($urandom);
            bus.y      = 19'($urandom);
            bus.y_size = 10'($urandom);
            bus.m      = 16'($urandom);
            @(posedge clk);
            #1;
            if (bus.ready) lat = n;
        end
        if (lat == 0) lat = -1;
        chk(32'(lat), 32'(expl), {tag, "_latency"});
        chk(32'(bus.out), 32'(expv), {tag, "_value"});
        if (hold) begin
            repeat (3) @(posedge clk);
            #1;
            chk(32'(bus.ready), 32'd1, {tag, "_held_start_single_op"});
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.x      = '0;
        bus.y      = '0;
        bus.y_size = '0;
        bus.m      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(32'(bus.ready), 32'd0, "reset_ready");
        chk(32'(bus.out), 32'd0, "reset_out");
        @(negedge clk);
        rst = 1'b1;

        run_op(16'd4, 19'd13, 10'd4, 16'd497, 0, 1'b0, 1'b0, "basic");
        chk(32'(bus.out), 32'd445, "basic_const");
        run_op(16'd65, 19'd17, 10'd5, 16'd3233, 0, 1'b0, 1'b1, "rsa_enc");
        chk(32'(bus.out), 32'd2790, "rsa_enc_const");
        run_op(16'd2790, 19'd2753, 10'd12, 16'd3233, 0, 1'b0, 1'b1, "rsa_dec");
        chk(32'(bus.out), 32'd65, "rsa_dec_const");
        run_op(16'd500, 19'd1, 10'd1, 16'd497, 0, 1'b0, 1'b1, "x_ge_m");
        chk(32'(bus.out), 32'd3, "x_ge_m_const");
        run_op(16'd123, 19'd5, 10'd0, 16'd497, 0, 1'b0, 1'b1, "size0");
        run_op(16'd9, 19'd7, 10'd3, 16'd1, 0, 1'b0, 1'b1, "m_one");
        run_op(16'd9, 19'd7, 10'd3, 16'd0, 0, 1'b0, 1'b1, "m_zero");
        run_op(16'd54321, 19'h5A5A5, 10'd1023, 16'd65521, 0, 1'b0, 1'b1, "clamp");
        run_op(16'd77, 19'd45, 10'd6, 16'd1009, 5, 1'b0, 1'b1, "pulse_reduce");
        run_op(16'd77, 19'd45, 10'd6, 16'd1009, 40, 1'b0, 1'b1, "pulse_square");
        run_op(16'd31, 19'd11, 10'd4, 16'd997, 0, 1'b1, 1'b1, "hold_start");

        // Abort mid-SQUARE, then confirm the engine recovers cleanly.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.x      = 16'd7;
        bus.y      = 19'h3FF;
        bus.y_size = 10'd10;
        bus.m      = 16'd1000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk(32'(bus.ready), 32'd0, "abort_ready");
        chk(32'(bus.out), 32'd0, "abort_out");
        @(negedge clk);
        rst = 1'b1;
        run_op(16'd7, 19'h3FF, 10'd10, 16'd1000, 0, 1'b0, 1'b0, "after_abort");

        for (int t = 0; t < 300; t++) begin
            logic [9:0]  ys;
            logic [15:0] m;
            ys = (t % 25 == 0) ? 10'($urandom_range(11, 1023)) : 10'($urandom_range(0, 10));
            m  = 16'($urandom_range(2, 65535));
            run_op(16'($urandom), 19'($urandom), ys, m, 0, 1'b0, 1'b1, $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
